conv5x5_filter: RTL and testbench

5x5 convolution stage of the HDMI filter path, directly downstream of the line-buffer delay block. Takes the five vertically aligned pixels of one column (rows a..e) each clock, builds a 5x5 window with column shift registers and multiplies it by 25 run-time programmable signed coefficients. It outputs one rounded-down, clamped 8-bit pixel per clock. The status bit is delayed so that it stays aligned with the filtered pixel.

---
 rtl/conv5x5_filter_if.sv | 22 ++
 rtl/conv5x5_filter.sv | 78 +++++++
 tb/tb_conv5x5_filter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/conv5x5_filter_if.sv
// conv5x5_filter_if: pixel column, status and coefficient write bus for the 5x5 convolution stage
interface conv5x5_filter_if;
    logic [7:0] pa;
    logic [7:0] pb;
    logic [7:0] pc;
    logic [7:0] pd;
    logic [7:0] pe;
    logic       stat_in;
    logic       coeff_we;
    logic [4:0] coeff_addr;
    logic [7:0] coeff_data;
    logic [7:0] dout;
    logic       stat_o;
    modport master (
        output pa, pb, pc, pd, pe, stat_in, coeff_we, coeff_addr, coeff_data,
        input  dout, stat_o
    );
    modport slave (
        input  pa, pb, pc, pd, pe, stat_in, coeff_we, coeff_addr, coeff_data,
        output dout, stat_o
    );
endinterface

// File: rtl/conv5x5_filter.sv
// conv5x5_filter: 5x5 window, programmable signed coefficients, floor-shift and clamp to 8 bits
module conv5x5_filter #(
    parameter int SHIFT = 4
) (
    input logic            clk,
    input logic            rst,
    conv5x5_filter_if.slave bus
);
    logic        [7:0]  col   [0:4][0:4];
    logic signed [7:0]  coef  [0:24];
    logic signed [16:0] prod  [0:24];
    logic signed [19:0] rsum  [0:4];
    logic signed [21:0] tot;
    logic signed [21:0] sh;
    logic        [7:0]  clamp;
    logic        [7:0]  dout_q;
    logic        [8:0]  sd;

    // column shift registers: col0 takes the new column, col4 holds the oldest
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int i = 0; i < 5; i++)
                for (int r = 0; r < 5; r++)
                    col[i][r] <= 8'd0;
        else begin
            for (int i = 4; i > 0; i--)
                col[i] <= col[i-1];
            col[0][0] <= bus.pa;
            col[0][1] <= bus.pb;
            col[0][2] <= bus.pc;
            col[0][3] <= bus.pd;
            col[0][4] <= bus.pe;
        end

    // coefficient bank: identity on reset, out-of-range addresses dropped
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int k = 0; k < 25; k++)
                coef[k] <= (k == 12) ? 8'(1 << SHIFT) : 8'sd0;
        else if (bus.coeff_we && bus.coeff_addr <= 5'd24)
            coef[bus.coeff_addr] <= bus.coeff_data;

    // multiply and sum pipeline; coefficient col index c reads window register 4-c
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int k = 0; k < 25; k++)
                prod[k] <= 17'sd0;
            for (int r = 0; r < 5; r++)
                rsum[r] <= 20'sd0;
            tot    <= 22'sd0;
            dout_q <= 8'd0;
        end else begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    prod[r*5+c] <= 17'($signed({1'b0, col[4-c][r]})) * 17'(coef[r*5+c]);
            for (int r = 0; r < 5; r++)
                rsum[r] <= 20'(prod[r*5]) + 20'(prod[r*5+1]) + 20'(prod[r*5+2])
                         + 20'(prod[r*5+3]) + 20'(prod[r*5+4]);
            tot    <= 22'(rsum[0]) + 22'(rsum[1]) + 22'(rsum[2]) + 22'(rsum[3]) + 22'(rsum[4]);
            dout_q <= clamp;
        end

    // floor shift then saturate into the unsigned pixel range
    always_comb begin
        sh    = tot >>> SHIFT;
        clamp = (sh < 0) ? 8'd0 : ((sh > 22'sd255) ? 8'd255 : sh[7:0]);
    end

    // status delay line matching the pixel path
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            sd <= 9'd0;
        else
            sd <= {sd[7:0], bus.stat_in};

    assign bus.dout   = dout_q;
    assign bus.stat_o = sd[8];
endmodule

// File: tb/tb_conv5x5_filter.sv
// tb_conv5x5_filter: directed vectors against hand-computed filter outputs
module tb_conv5x5_filter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    conv5x5_filter_if bus ();

    conv5x5_filter #(.SHIFT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input logic [7:0] v);
        bus.pa = v;
        bus.pb = v;
        bus.pc = v;
        bus.pd = v;
        bus.pe = v;
    endtask

    task automatic wr(input int k, input logic [7:0] v);
        bus.coeff_we   = 1'b1;
        bus.coeff_addr = 5'(k);
        bus.coeff_data = v;
        tick();
        bus.coeff_we   = 1'b0;
    endtask

    task automatic wr_all(input logic [7:0] v);
        for (int k = 0; k < 25; k++)
            wr(k, v);
    endtask

    task automatic identity_run(input string tag);
        set_px(8'd100);
        for (int i = 0; i < 10; i++) begin
            tick();
            check(tag, bus.dout, (i + 1 >= 7) ? 32'd100 : 32'd0);
        end
    endtask

    initial begin
        set_px(8'd0);
        bus.stat_in    = 1'b0;
        bus.coeff_we   = 1'b0;
        bus.coeff_addr = 5'd0;
        bus.coeff_data = 8'd0;
        repeat (3) tick();
        check("rst_dout", bus.dout, 0);
        check("rst_stat", bus.stat_o, 0);
        rst = 1'b1;
        identity_run("identity");

        set_px(8'd0);
        repeat (10) tick();
        for (int i = 0; i < 12; i++) begin
            bus.pc = (i == 0) ? 8'd255 : 8'd0;
            tick();
            check("impulse", bus.dout, (i + 1 == 7) ? 32'd255 : 32'd0);
        end

        for (int i = 0; i < 12; i++) begin
            bus.stat_in = (i == 0);
            bus.pc = (i == 2) ? 8'd255 : 8'd0;
            tick();
            check("stat_align", bus.stat_o, (i + 1 == 9) ? 32'd1 : 32'd0);
            check("stat_dout", bus.dout, (i + 1 == 9) ? 32'd255 : 32'd0);
        end

        wr(12, 8'd0);
        wr(0, 8'd8);
        wr(24, 8'd16);
        repeat (10) tick();
        for (int i = 0; i < 12; i++) begin
            bus.pa = (i == 0) ? 8'd255 : 8'd0;
            bus.pe = (i == 0) ? 8'd255 : 8'd0;
            tick();
            check("orient", bus.dout, (i + 1 == 5) ? 32'd255 : (i + 1 == 9) ? 32'd127 : 32'd0);
        end

        set_px(8'd16);
        wr_all(8'd1);
        repeat (10) tick();
        check("box", bus.dout, 25);
        wr(27, 8'd5);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("addr27", bus.dout, 25);
        end

        set_px(8'd200);
        wr_all(8'd0);
        wr(12, 8'h80);
        repeat (8) tick();
        check("clamp_lo", bus.dout, 0);
        wr(12, 8'd3);
        repeat (8) tick();
        check("floor", bus.dout, 37);

        set_px(8'd255);
        wr_all(8'd127);
        repeat (8) tick();
        check("clamp_hi", bus.dout, 255);

        set_px(8'd16);
        bus.stat_in = 1'b1;
        wr_all(8'd1);
        repeat (10) tick();
        check("pre_rst_dout", bus.dout, 25);
        check("pre_rst_stat", bus.stat_o, 1);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_dout", bus.dout, 0);
        check("mid_rst_stat", bus.stat_o, 0);
        bus.coeff_we   = 1'b1;
        bus.coeff_addr = 5'd12;
        bus.coeff_data = 8'd5;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.coeff_we = 1'b0;
        bus.stat_in  = 1'b0;
        rst = 1'b1;
        identity_run("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
